br_lite_local_if: RTL and testbench

Local-port network interface between one processing element and one BrLite router local port. It buffers PE-issued broadcast flits in a TX FIFO and injects them into the router with the req/ack handshake. It also accepts router-delivered flits with the same handshake into an RX FIFO that the PE drains through a valid/ready stream. One instance sits beside each router of the BrLite mesh, on the PE side of the local port.

---
 rtl/br_lite_local_if.sv | 124 ++++++++++++
 tb/tb_br_lite_local_if.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/br_lite_local_if.sv
// PE-side interface to a BrLite router local port: TX FIFO + req/ack injector,
// RX req/ack acceptor + RX FIFO drained by the PE over valid/ready.
module br_lite_local_if #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_flit_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_flit_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [DATA_W-1:0] noc_flit_o,
  output logic              noc_req_o,
  input  logic              noc_ack_i,
  input  logic              noc_busy_i,
  input  logic [DATA_W-1:0] noc_flit_i,
  input  logic              noc_req_i,
  output logic              noc_ack_o,
  output logic [31:0]       tx_cnt_o,
  output logic [31:0]       rx_cnt_o
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_ONE = {{TAW{1'b0}}, 1'b1};
  localparam logic [RAW:0] RX_ONE = {{RAW{1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_REQ} tx_state_e;

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [TAW:0]      tx_wr_q, tx_rd_q;
  logic [RAW:0]      rx_wr_q, rx_rd_q;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;

  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] nflit_q, nflit_d;
  logic              ack_q, ack_d;
  logic [31:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  // Wrap-bit pointers: equal index with differing MSB means full.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]) && (tx_wr_q[TAW] != tx_rd_q[TAW]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]) && (rx_wr_q[RAW] != rx_rd_q[RAW]);

  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && !tx_full;
  assign rx_valid_o = !rx_empty;
  assign rx_flit_o  = rx_mem_q[rx_rd_q[RAW-1:0]];
  assign rx_pop     = rx_valid_o && rx_ready_i;
  // Ack-low guard stops a second accept while the router is still dropping req.
  assign rx_push    = noc_req_i && !rx_full && !ack_q;

  assign noc_req_o  = (tx_state_q == S_REQ);
  assign noc_flit_o = nflit_q;
  assign noc_ack_o  = ack_q;
  assign tx_cnt_o   = tx_cnt_q;
  assign rx_cnt_o   = rx_cnt_q;

  always_comb begin
    tx_state_d = tx_state_q;
    nflit_d    = nflit_q;
    tx_pop     = 1'b0;
    tx_cnt_d   = tx_cnt_q;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty && !noc_busy_i) begin
          tx_state_d = S_REQ;
          nflit_d    = tx_mem_q[tx_rd_q[TAW-1:0]];
        end
      end
      S_REQ: begin
        if (noc_ack_i) begin
          tx_state_d = S_IDLE;
          tx_pop     = 1'b1;
          tx_cnt_d   = tx_cnt_q + 32'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d    = rx_push;
    rx_cnt_d = rx_push ? rx_cnt_q + 32'd1 : rx_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= S_IDLE;
      nflit_q    <= '0;
      ack_q      <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      nflit_q    <= nflit_d;
      ack_q      <= ack_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      if (tx_push) tx_wr_q <= tx_wr_q + TX_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + TX_ONE;
      if (rx_push) rx_wr_q <= rx_wr_q + RX_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_ONE;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q[TAW-1:0]] <= tx_flit_i;
    if (rx_push) rx_mem_q[rx_wr_q[RAW-1:0]] <= noc_flit_i;
  end

endmodule

// File: tb/tb_br_lite_local_if.sv
// Directed bench for br_lite_local_if: per-cycle vector table plus hand-written
// sequences for TX backpressure, busy gating, RX full and mid-transfer reset.
module tb_br_lite_local_if;

  logic        clk;
  logic        rst;
  logic [31:0] tx_flit;
  logic        tx_valid;
  logic        tx_ready_o;
  logic [31:0] rx_flit_o;
  logic        rx_valid_o;
  logic        rx_ready;
  logic [31:0] noc_flit_o;
  logic        noc_req_o;
  logic        noc_ack;
  logic        noc_busy;
  logic [31:0] noc_flit_in;
  logic        noc_req_in;
  logic        noc_ack_o;
  logic [31:0] tx_cnt_o;
  logic [31:0] rx_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  br_lite_local_if #(.TX_DEPTH(4), .RX_DEPTH(4), .DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_flit_i  (tx_flit),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready_o),
    .rx_flit_o  (rx_flit_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready),
    .noc_flit_o (noc_flit_o),
    .noc_req_o  (noc_req_o),
    .noc_ack_i  (noc_ack),
    .noc_busy_i (noc_busy),
    .noc_flit_i (noc_flit_in),
    .noc_req_i  (noc_req_in),
    .noc_ack_o  (noc_ack_o),
    .tx_cnt_o   (tx_cnt_o),
    .rx_cnt_o   (rx_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  typedef struct {
    logic        rst, tx_v;
    logic [31:0] tx_f;
    logic        rx_r, ack, busy, nreq;
    logic [31:0] nf_in;
    logic        e_txr, e_rxv;
    logic [31:0] e_rxf;
    logic        e_req, chk_nf;
    logic [31:0] e_nf;
    logic        e_ack;
    logic [31:0] e_txc, e_rxc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock; a flit offered and accepted at this edge is withdrawn afterwards.
  task automatic step();
    logic p;
    p = tx_valid && tx_ready_o;
    @(posedge clk);
    #1;
    if (p) tx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_flit = '0; rx_ready = 1'b0;
    noc_ack = 1'b0; noc_busy = 1'b0; noc_req_in = 1'b0; noc_flit_in = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 8 && !noc_req_o; k++) step();
    chk1("req_wait", noc_req_o, 1'b1);
  endtask

  logic [31:0] bflit [5];
  logic [31:0] dflit [5];

  initial begin
    logic [31:0] a, r;
    a = 32'hA5A5_A5A5;
    r = 32'h1111_1111;
    rst = 1'b1; tx_valid = 1'b0; tx_flit = '0; rx_ready = 1'b0;
    noc_ack = 1'b0; noc_busy = 1'b0; noc_req_in = 1'b0; noc_flit_in = '0;

    //          rst tx_v tx_f rx_r ack busy nreq nf_in | txr rxv rxf req chk_nf nf ack txc rxc
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, a, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, a, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, a, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, a, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 1, a, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, a, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, r,   1, 1, r, 0, 0, 0, 1, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, r,   1, 1, r, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 1, r, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; tx_valid = tbl[i].tx_v; tx_flit = tbl[i].tx_f;
      rx_ready = tbl[i].rx_r; noc_ack = tbl[i].ack; noc_busy = tbl[i].busy;
      noc_req_in = tbl[i].nreq; noc_flit_in = tbl[i].nf_in;
      step();
      chk1($sformatf("v%0d.tx_ready", i), tx_ready_o, tbl[i].e_txr);
      chk1($sformatf("v%0d.rx_valid", i), rx_valid_o, tbl[i].e_rxv);
      if (tbl[i].e_rxv) chk32($sformatf("v%0d.rx_flit", i), rx_flit_o, tbl[i].e_rxf);
      chk1($sformatf("v%0d.noc_req", i), noc_req_o, tbl[i].e_req);
      if (tbl[i].chk_nf) chk32($sformatf("v%0d.noc_flit", i), noc_flit_o, tbl[i].e_nf);
      chk1($sformatf("v%0d.noc_ack", i), noc_ack_o, tbl[i].e_ack);
      chk32($sformatf("v%0d.tx_cnt", i), tx_cnt_o, tbl[i].e_txc);
      chk32($sformatf("v%0d.rx_cnt", i), rx_cnt_o, tbl[i].e_rxc);
    end

    // TX backpressure: five flits into a four-deep FIFO, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) bflit[i] = 32'hB000_0000 + i;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_flit = bflit[i];
      step();
    end
    chk1("bp.ready_after4", tx_ready_o, 1'b0);
    tx_valid = 1'b1; tx_flit = bflit[4];
    step();
    chk1("bp.fifth_held", tx_ready_o, 1'b0);
    chk1("bp.req_up", noc_req_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_req();
      chk32($sformatf("bp.flit%0d", i), noc_flit_o, bflit[i]);
      noc_ack = 1'b1;
      step();
      noc_ack = 1'b0;
      chk1($sformatf("bp.req_drop%0d", i), noc_req_o, 1'b0);
    end
    chk32("bp.tx_cnt", tx_cnt_o, 32'd5);
    chk1("bp.ready_end", tx_ready_o, 1'b1);

    // Busy gating: no request while busy, request one cycle after release.
    do_reset();
    noc_busy = 1'b1; tx_valid = 1'b1; tx_flit = 32'hC0C0_C0C0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk1($sformatf("busy.no_req%0d", i), noc_req_o, 1'b0);
    end
    noc_busy = 1'b0;
    step();
    chk1("busy.req_after_release", noc_req_o, 1'b1);
    chk32("busy.flit", noc_flit_o, 32'hC0C0_C0C0);
    noc_busy = 1'b1;
    step(); step();
    chk1("busy.req_held", noc_req_o, 1'b1);
    noc_ack = 1'b1;
    step();
    noc_ack = 1'b0; noc_busy = 1'b0;
    chk1("busy.req_dropped", noc_req_o, 1'b0);
    chk32("busy.tx_cnt", tx_cnt_o, 32'd1);

    // RX full: four single-cycle acks, fifth waits for a PE pop.
    do_reset();
    for (int i = 0; i < 5; i++) dflit[i] = 32'hD000_0000 + i;
    for (int i = 0; i < 4; i++) begin
      noc_req_in = 1'b1; noc_flit_in = dflit[i];
      step();
      chk1($sformatf("rxf.ack%0d", i), noc_ack_o, 1'b1);
      noc_req_in = 1'b0;
      step();
      chk1($sformatf("rxf.ack_low%0d", i), noc_ack_o, 1'b0);
    end
    chk32("rxf.cnt4", rx_cnt_o, 32'd4);
    noc_req_in = 1'b1; noc_flit_in = dflit[4];
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("rxf.pending%0d", i), noc_ack_o, 1'b0);
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk1("rxf.no_ack_on_pop_edge", noc_ack_o, 1'b0);
    step();
    chk1("rxf.ack_after_pop", noc_ack_o, 1'b1);
    noc_req_in = 1'b0;
    chk32("rxf.cnt5", rx_cnt_o, 32'd5);
    for (int i = 1; i < 5; i++) begin
      chk1($sformatf("rxf.valid%0d", i), rx_valid_o, 1'b1);
      chk32($sformatf("rxf.head%0d", i), rx_flit_o, dflit[i]);
      rx_ready = 1'b1;
      step();
    end
    rx_ready = 1'b0;
    chk1("rxf.empty", rx_valid_o, 1'b0);

    // Reset mid-transfer: request pending, three flits in each FIFO.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_flit = 32'hE000_0000 + i;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      noc_req_in = 1'b1; noc_flit_in = 32'hF000_0000 + i;
      step();
      noc_req_in = 1'b0;
      step();
    end
    chk1("mrst.pre_req", noc_req_o, 1'b1);
    chk32("mrst.pre_rxcnt", rx_cnt_o, 32'd3);
    rst = 1'b1;
    step();
    chk1("mrst.req", noc_req_o, 1'b0);
    chk1("mrst.ack", noc_ack_o, 1'b0);
    chk32("mrst.noc_flit", noc_flit_o, 32'd0);
    chk1("mrst.tx_ready", tx_ready_o, 1'b1);
    chk1("mrst.rx_valid", rx_valid_o, 1'b0);
    chk32("mrst.tx_cnt", tx_cnt_o, 32'd0);
    chk32("mrst.rx_cnt", rx_cnt_o, 32'd0);
    rst = 1'b0;
    step(); step();
    chk1("mrst.post_req", noc_req_o, 1'b0);
    chk1("mrst.post_rx_valid", rx_valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
